// File: rtl/rv_p4_pkg.sv
// Shared types for the RV-P4 match-action unit: stateful op codes and
// the stateful ALU sequencing states.
package rv_p4_pkg;

  typedef enum logic [1:0] {
    READ  = 2'd0,
    WRITE = 2'd1,
    ADD   = 2'd2,
    CAS   = 2'd3
  } stat_op_t;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } stat_alu_state_t;

endpackage

// File: rtl/stat_sram_1r1w.sv
// Simple dual-port word store: one registered read port, one write port.
// A read that hits the word being written in the same cycle returns the old data.
module stat_sram_1r1w #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4096,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mau_stateful_alu.sv
// Stateful ALU: 3-stage read-modify-write over a word array with full
// same-address forwarding, plus an INIT/RUN/DRAIN clear sequencer.
module mau_stateful_alu
  import rv_p4_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 4096,
  parameter bit SAT_ADD = 1'b1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  stat_op_t          req_op,
  input  logic [AW-1:0]     req_addr,
  input  logic [DATA_W-1:0] req_operand,
  input  logic [DATA_W-1:0] req_cmp,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_old,
  output logic [DATA_W-1:0] rsp_new,
  output logic              rsp_flag,
  input  logic              clr_start,
  output logic              init_done
);

  stat_alu_state_t state_reg, state_next;
  logic [AW-1:0]   init_cnt_reg;
  logic            init_we;
  logic            accept;

  // Stage 1: request captured, SRAM read in flight
  logic              s1_valid_reg;
  stat_op_t          s1_op_reg;
  logic [AW-1:0]     s1_addr_reg;
  logic [DATA_W-1:0] s1_operand_reg;
  logic [DATA_W-1:0] s1_cmp_reg;
  logic [DATA_W-1:0] s1_old;

  // Stage 2: old value resolved, ALU evaluates, writeback at the next edge
  logic              s2_valid_reg;
  stat_op_t          s2_op_reg;
  logic [AW-1:0]     s2_addr_reg;
  logic [DATA_W-1:0] s2_operand_reg;
  logic [DATA_W-1:0] s2_cmp_reg;
  logic [DATA_W-1:0] s2_old_reg;

  logic [AW-1:0]     wb_addr_reg;
  logic [DATA_W:0]   alu_sum;
  logic [DATA_W-1:0] alu_new;
  logic              alu_flag;
  logic              alu_we;

  logic              sram_we;
  logic [AW-1:0]     sram_waddr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= INIT;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      INIT:    if (init_cnt_reg == AW'(DEPTH - 1)) state_next = RUN;
      RUN:     if (clr_start) state_next = DRAIN;
      DRAIN:   if (!s1_valid_reg && !s2_valid_reg) state_next = INIT;
      default: state_next = INIT;
    endcase
  end

  always_comb begin
    req_ready = (state_reg == RUN);
    init_done = (state_reg == RUN);
    init_we   = (state_reg == INIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  init_cnt_reg <= '0;
    else if (state_reg == INIT)  init_cnt_reg <= init_cnt_reg + 1'b1;
    else                         init_cnt_reg <= '0;
  end

  // Newest pending write wins: stage 2 result, then the word written at the last edge.
  always_comb begin
    s1_old = sram_rdata;
    if (rsp_valid && wb_addr_reg == s1_addr_reg)    s1_old = rsp_new;
    if (s2_valid_reg && s2_addr_reg == s1_addr_reg) s1_old = alu_new;
  end

  always_comb begin
    alu_sum  = {1'b0, s2_old_reg} + {1'b0, s2_operand_reg};
    alu_new  = s2_old_reg;
    alu_flag = 1'b0;
    alu_we   = 1'b0;
    case (s2_op_reg)
      WRITE: begin
        alu_new = s2_operand_reg;
        alu_we  = 1'b1;
      end
      ADD: begin
        alu_we = 1'b1;
        if (SAT_ADD && alu_sum[DATA_W]) begin
          alu_new  = '1;
          alu_flag = 1'b1;
        end else begin
          alu_new = alu_sum[DATA_W-1:0];
        end
      end
      CAS: begin
        if (s2_old_reg == s2_cmp_reg) begin
          alu_new  = s2_operand_reg;
          alu_we   = 1'b1;
          alu_flag = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      s1_op_reg      <= READ;
      s1_addr_reg    <= '0;
      s1_operand_reg <= '0;
      s1_cmp_reg     <= '0;
      s2_valid_reg   <= 1'b0;
      s2_op_reg      <= READ;
      s2_addr_reg    <= '0;
      s2_operand_reg <= '0;
      s2_cmp_reg     <= '0;
      s2_old_reg     <= '0;
      wb_addr_reg    <= '0;
      rsp_valid      <= 1'b0;
      rsp_old        <= '0;
      rsp_new        <= '0;
      rsp_flag       <= 1'b0;
    end else begin
      s1_valid_reg   <= accept;
      s1_op_reg      <= req_op;
      s1_addr_reg    <= req_addr;
      s1_operand_reg <= req_operand;
      s1_cmp_reg     <= req_cmp;
      s2_valid_reg   <= s1_valid_reg;
      s2_op_reg      <= s1_op_reg;
      s2_addr_reg    <= s1_addr_reg;
      s2_operand_reg <= s1_operand_reg;
      s2_cmp_reg     <= s1_cmp_reg;
      s2_old_reg     <= s1_old;
      wb_addr_reg    <= s2_addr_reg;
      rsp_valid      <= s2_valid_reg;
      rsp_old        <= s2_valid_reg ? s2_old_reg : '0;
      rsp_new        <= s2_valid_reg ? alu_new : '0;
      rsp_flag       <= s2_valid_reg && alu_flag;
    end
  end

  // The clear sweep owns the write port in INIT; nothing is in flight then.
  always_comb begin
    sram_we    = init_we || (s2_valid_reg && alu_we);
    sram_waddr = init_we ? init_cnt_reg : s2_addr_reg;
    sram_wdata = init_we ? '0 : alu_new;
  end

  stat_sram_1r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_sram (
    .clk   (clk),
    .raddr (req_addr),
    .rdata (sram_rdata),
    .we    (sram_we),
    .waddr (sram_waddr),
    .wdata (sram_wdata)
  );

endmodule

// File: tb/tb_mau_stateful_alu.sv
// Bench for mau_stateful_alu: saturating and wrapping instances share stimulus
// and are scored every cycle against an array model of the word store.
module tb_mau_stateful_alu;
  import rv_p4_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam longint MAXV = 255;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_valid = 1'b0;
  logic           clr_start = 1'b0;
  stat_op_t       req_op = READ;
  logic [AW-1:0]  req_addr = '0;
  logic [DW-1:0]  req_operand = '0;
  logic [DW-1:0]  req_cmp = '0;

  logic           rdy_s, rdy_w, rv_s, rv_w, fl_s, fl_w, done_s, done_w;
  logic [DW-1:0]  old_s, new_s, old_w, new_w;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mau_stateful_alu #(.DATA_W(DW), .DEPTH(DEPTH), .SAT_ADD(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_s),
    .req_op(req_op), .req_addr(req_addr), .req_operand(req_operand), .req_cmp(req_cmp),
    .rsp_valid(rv_s), .rsp_old(old_s), .rsp_new(new_s), .rsp_flag(fl_s),
    .clr_start(clr_start), .init_done(done_s)
  );

  mau_stateful_alu #(.DATA_W(DW), .DEPTH(DEPTH), .SAT_ADD(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_w),
    .req_op(req_op), .req_addr(req_addr), .req_operand(req_operand), .req_cmp(req_cmp),
    .rsp_valid(rv_w), .rsp_old(old_w), .rsp_new(new_w), .rsp_flag(fl_w),
    .clr_start(clr_start), .init_done(done_w)
  );

  typedef struct {
    bit     v;
    longint os, ns, ow, nw;
    bit     fs, fw;
  } exp_t;

  // Model: word arrays per instance, phase 0=clearing 1=serving 2=draining
  longint mem_m [2][DEPTH];
  int     phase;
  int     init_left;
  exp_t   a1, a2, none_e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0t obs=%0h exp=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic void clear_model();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DEPTH; i++) mem_m[k][i] = 0;
  endfunction

  function automatic void apply(input int k, input stat_op_t op, input int addr,
                                input longint opnd, input longint cmp, input bit sat,
                                output longint o, output longint n, output bit f);
    o = mem_m[k][addr];
    n = o;
    f = 1'b0;
    case (op)
      WRITE: n = opnd;
      ADD: begin
        n = o + opnd;
        if (n > MAXV) begin
          if (sat) begin n = MAXV; f = 1'b1; end
          else n = n - (MAXV + 1);
        end
      end
      CAS: if (o == cmp) begin n = opnd; f = 1'b1; end
      default: ;
    endcase
    mem_m[k][addr] = n;
  endfunction

  // One clock: score handshake, step the model across the edge, score responses.
  task automatic cycle();
    bit   exp_rdy, acc;
    exp_t nw, cur;
    exp_rdy = rst_n && (phase == 1);
    chk("req_ready_sat", rdy_s, exp_rdy);
    chk("req_ready_wrap", rdy_w, exp_rdy);
    chk("init_done", done_s, exp_rdy);
    acc = req_valid && exp_rdy;
    nw = none_e;
    if (acc) begin
      nw.v = 1'b1;
      apply(0, req_op, int'(req_addr), longint'(req_operand), longint'(req_cmp), 1'b1, nw.os, nw.ns, nw.fs);
      apply(1, req_op, int'(req_addr), longint'(req_operand), longint'(req_cmp), 1'b0, nw.ow, nw.nw, nw.fw);
    end
    @(posedge clk);
    if (!rst_n) begin
      phase = 0; init_left = DEPTH;
    end else begin
      case (phase)
        0: begin init_left--; if (init_left == 0) phase = 1; end
        1: if (clr_start) phase = 2;
        default: if (!a1.v && !a2.v) begin phase = 0; init_left = DEPTH; clear_model(); end
      endcase
    end
    cur = a2; a2 = a1; a1 = nw;
    if (!rst_n) begin cur = none_e; a1 = none_e; a2 = none_e; end
    #1;
    chk("rsp_valid_sat", rv_s, cur.v);
    chk("rsp_old_sat", old_s, cur.os);
    chk("rsp_new_sat", new_s, cur.ns);
    chk("rsp_flag_sat", fl_s, cur.fs);
    chk("rsp_valid_wrap", rv_w, cur.v);
    chk("rsp_old_wrap", old_w, cur.ow);
    chk("rsp_new_wrap", new_w, cur.nw);
    chk("rsp_flag_wrap", fl_w, cur.fw);
    if (acc || cur.v)
      $display("txn t=%0t acc=%0b op=%s addr=%0d rsp=%0b old=%0d/%0d new=%0d/%0d flag=%0b/%0b",
               $time, acc, req_op.name(), req_addr, rv_s, old_s, old_w, new_s, new_w, fl_s, fl_w);
  endtask

  task automatic issue(input stat_op_t op, input int addr, input int opnd, input int cmp);
    req_valid = 1'b1;
    req_op = op;
    req_addr = AW'(addr);
    req_operand = DW'(opnd);
    req_cmp = DW'(cmp);
    cycle();
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    phase = 0; init_left = DEPTH; a1 = none_e; a2 = none_e;
    clear_model();
    #1;
    chk("rst_ready", rdy_s, 1'b0);
    chk("rst_rsp_valid", rv_s, 1'b0);
    chk("rst_rsp_new", new_w, '0);
    chk("rst_init_done", done_w, 1'b0);
    for (int i = 0; i < hold; i++) cycle();
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string tag, input bit check_len);
    int n;
    n = 0;
    req_valid = 1'b0;
    while (!done_s && n < 200) begin cycle(); n++; end
    chk(tag, done_s, 1'b1);
    if (check_len) chk({tag, "_cycles"}, n, DEPTH);
  endtask

  initial begin
    none_e = '{v: 1'b0, os: 0, ns: 0, ow: 0, nw: 0, fs: 1'b0, fw: 1'b0};
    do_reset(3);
    wait_done("init_after_reset", 1'b1);

    for (int a = 0; a < DEPTH; a++) issue(READ, a, 0, 0);
    idle(3);

    for (int i = 0; i < 4; i++) issue(ADD, 3, 5, 0);
    idle(3);

    issue(WRITE, 1, 250, 0);
    issue(ADD, 1, 10, 0);
    idle(3);

    issue(WRITE, 9, 7, 0);
    issue(CAS, 9, 42, 7);
    issue(CAS, 9, 1, 7);
    idle(3);

    for (int i = 0; i < 300; i++) begin
      int a;
      a = int'($urandom_range(0, 7));
      req_valid = ($urandom_range(0, 3) != 0);
      req_op = stat_op_t'($urandom_range(0, 3));
      req_addr = AW'(a);
      req_operand = ($urandom_range(0, 1) != 0) ? DW'($urandom_range(0, 40)) : DW'($urandom_range(0, 255));
      req_cmp = ($urandom_range(0, 1) != 0) ? DW'(mem_m[0][a]) : DW'($urandom_range(0, 255));
      cycle();
    end
    idle(3);

    // Clear with two requests in flight; requests offered while draining must be refused.
    issue(ADD, 2, 1, 0);
    clr_start = 1'b1;
    issue(ADD, 2, 3, 0);
    clr_start = 1'b0;
    issue(WRITE, 5, 99, 0);
    issue(WRITE, 5, 99, 0);
    issue(WRITE, 5, 99, 0);
    req_valid = 1'b0;
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    wait_done("init_after_clear", 1'b0);
    for (int a = 0; a < DEPTH; a++) issue(READ, a, 0, 0);
    idle(3);

    // Reset one cycle after an accept: the response must never appear.
    issue(WRITE, 4, 77, 0);
    idle(1);
    do_reset(2);
    wait_done("init_after_midreset", 1'b1);
    issue(READ, 4, 0, 0);
    issue(ADD, 4, 200, 0);
    issue(ADD, 4, 100, 0);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mau_stateful_alu.md
MAU_STATEFUL_ALU -- requirements
Module: mau_stateful_alu

Interface
REQ-001 SHALL have parameter DATA_W, default 64, stateful word width in bits (legal 8..128).
REQ-002 SHALL have parameter DEPTH, default 4096, number of words (power of two, >=16); AW = $clog2(DEPTH).
REQ-003 SHALL have parameter SAT_ADD, default 1, 1 = saturating ADD, 0 = wrapping ADD.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted when req_valid&&req_ready at an edge.
REQ-008 SHALL have port req_op  input  2  stat_op_t: READ/WRITE/ADD/CAS.
REQ-009 SHALL have port req_addr  input  AW  word index.
REQ-010 SHALL have port req_operand  input  DATA_W  write data / addend / CAS swap value.
REQ-011 SHALL have port req_cmp  input  DATA_W  CAS compare value.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle pulse per accepted request; no backpressure.
REQ-013 SHALL have port rsp_old  output  DATA_W  word value before the operation.
REQ-014 SHALL have port rsp_new  output  DATA_W  word value after the operation.
REQ-015 SHALL have port rsp_flag  output  1  CAS: compare matched; ADD: saturated; else 0.
REQ-016 SHALL have port clr_start  input  1  pulse requesting clear of all words.
REQ-017 SHALL have port init_done  output  1  high when array is cleared and requests are accepted.

Function
REQ-018 SHALL use FSM states INIT, RUN, DRAIN; reset enters INIT.
REQ-019 INIT SHALL write zero to addresses 0..DEPTH-1, one per cycle, ascending; after DEPTH cycles SHALL go to RUN.
REQ-020 req_ready and init_done SHALL be 1 only in RUN; in INIT/DRAIN both 0.
REQ-021 clr_start in RUN SHALL go to DRAIN; DRAIN SHALL go to INIT once no request is in flight; clr_start in INIT/DRAIN SHALL be ignored.
REQ-022 Request accepted at edge N SHALL produce rsp_valid high exactly in the cycle after edge N+2; writeback commits at edge N+2.
REQ-023 One request SHALL be acceptable per cycle (full throughput in RUN).
REQ-024 rsp_old SHALL reflect all previously accepted requests, including same-address requests 1 or 2 cycles earlier (forwarding mandatory).
REQ-025 READ: new=old, no write, flag=0. WRITE: new=operand, flag=0.
REQ-026 ADD, SAT_ADD=1: new=min(old+operand, 2^DATA_W-1), flag=1 iff clamped; SAT_ADD=0: new=(old+operand) mod 2^DATA_W, flag=0.
REQ-027 CAS: if old==req_cmp then new=operand, write, flag=1; else new=old, no write, flag=0.
REQ-028 rsp_old/rsp_new/rsp_flag SHALL be 0 whenever rsp_valid=0.
REQ-029 Array contents are undefined until first INIT completes; no read SHALL be possible before then.

Reset
REQ-030 rst_n low SHALL immediately force req_ready=0, rsp_valid=0, init_done=0, rsp_* =0, FSM=INIT, init counter=0.
REQ-031 Reset mid-operation SHALL discard in-flight requests without responses; INIT restarts from address 0 after release.
REQ-032 Memory array itself SHALL NOT be reset (cleared only by INIT).

Structure
REQ-033 stat_op_t is reused from rv_p4_pkg; new enum stat_alu_state_t {INIT,RUN,DRAIN} SHALL be added to rv_p4_pkg.
REQ-034 Storage SHALL be one sub-module stat_sram_1r1w (DATA_W x DEPTH, 1-cycle registered read, 1 write port, read-during-write returns old data).
REQ-035 Forwarding, ALU and FSM SHALL live in mau_stateful_alu.

Verification
REQ-036 Reset release, DEPTH=16 -> init_done rises after exactly 16 cycles; READ of every address returns 0.
REQ-037 ADD operand 5 to addr 3 on 4 consecutive cycles -> rsp_old 0,5,10,15; rsp_new 5,10,15,20.
REQ-038 DATA_W=8, SAT_ADD=1: WRITE 250 then ADD 10 -> rsp_new 255, flag 1; SAT_ADD=0 -> rsp_new 4, flag 0.
REQ-039 WRITE 7 to addr 9; CAS cmp 7 swap 42 -> flag 1, new 42; next-cycle CAS cmp 7 swap 1 -> flag 0, rsp_old 42.
REQ-040 clr_start with 2 requests in flight -> both responses delivered, req_ready low, DEPTH-cycle INIT, then all reads 0.
REQ-041 rst_n asserted one cycle after an accept -> no rsp_valid, INIT restarts, init_done after DEPTH cycles.
